// File: rtl/bullet_pool_ctrl_pkg.sv
// Shared bullet geometry, colour and pool defaults for the player bullet pool.
// Pure constants and helpers; no state.
package bullet_pool_ctrl_pkg;

    typedef logic signed [11:0] coord_t;

    localparam int VRES         = 480;
    localparam int PADDLE_H     = 16;
    localparam int BULLET_W     = 2;
    localparam int BULLET_H     = 8;
    localparam int BULLET_SPEED = 4;
    localparam logic [23:0] BULLET_COLOR = 24'hFFFF00;

    localparam int BULLET_SLOTS    = 4;
    localparam int BULLET_COOLDOWN = 8;

    localparam coord_t SPAWN_Y        = coord_t'(VRES - PADDLE_H - BULLET_H);
    localparam coord_t BULLET_HALF    = coord_t'(BULLET_W >> 1);
    localparam coord_t BULLET_H_C     = coord_t'(BULLET_H);
    localparam coord_t BULLET_SPEED_C = coord_t'(BULLET_SPEED);

    function automatic logic in_span(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: active/x/y state, spawn/move/retire/kill, and raster hit test.
// State updates on the clock edge; hit output is combinational from registered state.
module bullet_slot
    import bullet_pool_ctrl_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   fsync_i,
    input  logic   spawn_i,
    input  logic   kill_i,
    input  coord_t spawn_x_i,
    input  coord_t hpos_i,
    input  coord_t vpos_i,
    output logic   active_o,
    output coord_t x_o,
    output coord_t y_o,
    output logic   hit_o
);

    logic   active_q, active_d;
    coord_t x_q, x_d;
    coord_t y_q, y_d;

    always_comb begin
        active_d = active_q;
        x_d      = x_q;
        y_d      = y_q;
        // Kill wins over motion; spawn only ever targets a slot that was idle.
        if (kill_i && active_q) begin
            active_d = 1'b0;
        end else if (fsync_i && active_q) begin
            if (y_q > BULLET_SPEED_C) begin
                y_d = y_q - BULLET_SPEED_C;
            end else begin
                active_d = 1'b0;
            end
        end
        if (spawn_i) begin
            active_d = 1'b1;
            x_d      = spawn_x_i;
            y_d      = SPAWN_Y;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            active_q <= active_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    assign active_o = active_q;
    assign x_o      = x_q;
    assign y_o      = y_q;
    assign hit_o    = active_q
                    && in_span(hpos_i, x_q - BULLET_HALF, x_q + BULLET_HALF)
                    && in_span(vpos_i, y_q, y_q + BULLET_H_C);

endmodule

// File: rtl/bullet_pool_ctrl.sv
// Player bullet pool: synchronised fire request, frame cooldown, lowest-free allocation.
// Spawn/retire land one edge after fsync/kill; free_count trails slot_active by one cycle.
module bullet_pool_ctrl
    import bullet_pool_ctrl_pkg::*;
#(
    parameter int NUM_SLOTS       = BULLET_SLOTS,
    parameter int COOLDOWN_FRAMES = BULLET_COOLDOWN
) (
    input  logic                           pixel_clk,
    input  logic                           rst,
    input  logic                           fsync,
    input  logic                           fire,
    input  coord_t                         player_x,
    input  coord_t                         hpos,
    input  coord_t                         vpos,
    input  logic [NUM_SLOTS-1:0]           kill,
    output logic [7:0]                     pixel [0:2],
    output logic                           active,
    output logic [NUM_SLOTS-1:0]           slot_hit,
    output logic [NUM_SLOTS-1:0]           slot_active,
    output coord_t [NUM_SLOTS-1:0]         bullet_x,
    output coord_t [NUM_SLOTS-1:0]         bullet_y,
    output logic [$clog2(NUM_SLOTS+1)-1:0] free_count,
    output logic                           fire_dropped
);

    localparam int FW = $clog2(NUM_SLOTS + 1);
    localparam int CW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    logic [2:0]           sync_q;
    logic                 fire_prev_q;
    logic                 fire_edge;
    logic                 pending_q, pending_d;
    logic [CW-1:0]        cd_q, cd_d;
    logic [FW-1:0]        free_q, free_d;
    logic                 dropped_q, dropped_d;
    logic                 any_free;
    logic                 spawn_ok;
    logic                 found;
    logic [NUM_SLOTS-1:0] spawn_vec;

    assign fire_edge = sync_q[2] & ~fire_prev_q;
    assign any_free  = ~&slot_active;
    assign spawn_ok  = fsync && pending_q && (cd_q == '0) && any_free;

    always_comb begin
        spawn_vec = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!slot_active[i] && !found) begin
                spawn_vec[i] = spawn_ok;
                found        = 1'b1;
            end
        end
    end

    always_comb begin
        pending_d = pending_q;
        cd_d      = cd_q;
        dropped_d = 1'b0;
        free_d    = '0;
        // An edge coinciding with fsync is deliberately discarded with the request.
        if (fsync) begin
            pending_d = 1'b0;
        end else if (fire_edge) begin
            pending_d = 1'b1;
        end
        if (fsync && (cd_q != '0)) begin
            cd_d = cd_q - CW'(1);
        end
        if (spawn_ok) begin
            cd_d = CW'(COOLDOWN_FRAMES);
        end
        if (fsync && pending_q && !spawn_ok) begin
            dropped_d = 1'b1;
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            free_d = free_d + FW'(!slot_active[i]);
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            sync_q      <= '0;
            fire_prev_q <= 1'b0;
            pending_q   <= 1'b0;
            cd_q        <= '0;
            free_q      <= FW'(NUM_SLOTS);
            dropped_q   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[1:0], fire};
            fire_prev_q <= sync_q[2];
            pending_q   <= pending_d;
            cd_q        <= cd_d;
            free_q      <= free_d;
            dropped_q   <= dropped_d;
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        bullet_slot u_slot (
            .clk_i     (pixel_clk),
            .rst_i     (rst),
            .fsync_i   (fsync),
            .spawn_i   (spawn_vec[g]),
            .kill_i    (kill[g]),
            .spawn_x_i (player_x),
            .hpos_i    (hpos),
            .vpos_i    (vpos),
            .active_o  (slot_active[g]),
            .x_o       (bullet_x[g]),
            .y_o       (bullet_y[g]),
            .hit_o     (slot_hit[g])
        );
    end

    assign active       = |slot_hit;
    assign free_count   = free_q;
    assign fire_dropped = dropped_q;

    always_comb begin
        pixel[2] = active ? BULLET_COLOR[23:16] : 8'h00;
        pixel[1] = active ? BULLET_COLOR[15:8]  : 8'h00;
        pixel[0] = active ? BULLET_COLOR[7:0]   : 8'h00;
    end

endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// Directed bench for bullet_pool_ctrl: default instance plus a zero-cooldown instance.
module tb_bullet_pool_ctrl;

    logic               pixel_clk = 1'b0;
    logic               rst = 1'b1;
    logic               fsync = 1'b0;
    logic               fire_a = 1'b0;
    logic               fire_b = 1'b0;
    logic signed [11:0] player_x = '0;
    logic signed [11:0] hpos = '0;
    logic signed [11:0] vpos = '0;
    logic [3:0]         kill_a = '0;
    logic [3:0]         kill_b = '0;

    logic [7:0]              pixel_a [0:2];
    logic                    active_a;
    logic [3:0]              slot_hit_a;
    logic [3:0]              slot_active_a;
    logic [3:0][11:0]        bullet_x_a;
    logic [3:0][11:0]        bullet_y_a;
    logic [2:0]              free_count_a;
    logic                    fire_dropped_a;

    logic [7:0]              pixel_b [0:2];
    logic                    active_b;
    logic [3:0]              slot_hit_b;
    logic [3:0]              slot_active_b;
    logic [3:0][11:0]        bullet_x_b;
    logic [3:0][11:0]        bullet_y_b;
    logic [2:0]              free_count_b;
    logic                    fire_dropped_b;

    int errors = 0;
    int checks = 0;

    always #5 pixel_clk = ~pixel_clk;

    bullet_pool_ctrl dut_a (
        .pixel_clk    (pixel_clk),
        .rst          (rst),
        .fsync        (fsync),
        .fire         (fire_a),
        .player_x     (player_x),
        .hpos         (hpos),
        .vpos         (vpos),
        .kill         (kill_a),
        .pixel        (pixel_a),
        .active       (active_a),
        .slot_hit     (slot_hit_a),
        .slot_active  (slot_active_a),
        .bullet_x     (bullet_x_a),
        .bullet_y     (bullet_y_a),
        .free_count   (free_count_a),
        .fire_dropped (fire_dropped_a)
    );

    bullet_pool_ctrl #(.NUM_SLOTS(4), .COOLDOWN_FRAMES(0)) dut_b (
        .pixel_clk    (pixel_clk),
        .rst          (rst),
        .fsync        (fsync),
        .fire         (fire_b),
        .player_x     (player_x),
        .hpos         (hpos),
        .vpos         (vpos),
        .kill         (kill_b),
        .pixel        (pixel_b),
        .active       (active_b),
        .slot_hit     (slot_hit_b),
        .slot_active  (slot_active_b),
        .bullet_x     (bullet_x_b),
        .bullet_y     (bullet_y_b),
        .free_count   (free_count_b),
        .fire_dropped (fire_dropped_b)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic press(input bit sel_b);
        if (sel_b) fire_b = 1'b1; else fire_a = 1'b1;
        repeat (5) tick();
        fire_a = 1'b0;
        fire_b = 1'b0;
        repeat (4) tick();
    endtask

    task automatic frame();
        fsync = 1'b1;
        tick();
        fsync = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic point(input string tag, input int x, input int y, input bit exp_on);
        hpos = 12'(x);
        vpos = 12'(y);
        #1;
        chk({tag, "_active"}, 32'(active_a), 32'(exp_on));
        chk({tag, "_pixel"}, 32'({pixel_a[2], pixel_a[1], pixel_a[0]}),
            exp_on ? 32'h00FFFF00 : 32'h0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_slot_active", 32'(slot_active_a), 0);
        chk("rst_free_count", 32'(free_count_a), 4);
        chk("rst_dropped", 32'(fire_dropped_a), 0);
        chk("rst_active", 32'(active_a), 0);
        chk("rst_bullet_x0", 32'(signed'(bullet_x_a[0])), 0);

        // First spawn into slot 0
        player_x = 12'sd320;
        press(1'b0);
        frame();
        chk("spawn_active", 32'(slot_active_a), 32'b0001);
        chk("spawn_x0", 32'(signed'(bullet_x_a[0])), 320);
        chk("spawn_y0", 32'(signed'(bullet_y_a[0])), 456);
        chk("spawn_no_drop", 32'(fire_dropped_a), 0);
        chk("spawn_free_lag", 32'(free_count_a), 4);
        tick();
        chk("spawn_free", 32'(free_count_a), 3);

        // Cooldown: frames 2..9 dropped, frame 10 spawns slot 1
        player_x = 12'sd500;
        for (int f = 2; f <= 10; f++) begin
            press(1'b0);
            frame();
            chk($sformatf("cd_drop_f%0d", f), 32'(fire_dropped_a), (f < 10) ? 1 : 0);
            tick();
            chk($sformatf("cd_pulse_f%0d", f), 32'(fire_dropped_a), 0);
        end
        chk("cd_active", 32'(slot_active_a), 32'b0011);
        chk("cd_x1", 32'(signed'(bullet_x_a[1])), 500);
        chk("cd_y1", 32'(signed'(bullet_y_a[1])), 456);
        chk("cd_y0", 32'(signed'(bullet_y_a[0])), 420);

        // Kill mid-frame on active slot 1, then on inactive slot 3
        hpos = 12'sd500;
        vpos = 12'sd456;
        #1;
        chk("pre_kill_hit1", 32'(slot_hit_a[1]), 1);
        kill_a = 4'b0010;
        tick();
        kill_a = 4'b0000;
        chk("kill_active", 32'(slot_active_a), 32'b0001);
        chk("kill_hit1", 32'(slot_hit_a[1]), 0);
        kill_a = 4'b1000;
        tick();
        kill_a = 4'b0000;
        chk("kill_inactive", 32'(slot_active_a), 32'b0001);

        // Motion down to the top-of-screen retire boundary
        repeat (102) frame();
        chk("mv_y12", 32'(signed'(bullet_y_a[0])), 12);
        frame();
        chk("mv_y8", 32'(signed'(bullet_y_a[0])), 8);
        frame();
        chk("mv_y4", 32'(signed'(bullet_y_a[0])), 4);
        chk("mv_live4", 32'(slot_active_a[0]), 1);
        frame();
        chk("mv_retired", 32'(slot_active_a[0]), 0);

        // Raster check with slot at (100,200)
        player_x = 12'sd100;
        press(1'b0);
        frame();
        repeat (64) frame();
        chk("ras_x", 32'(signed'(bullet_x_a[0])), 100);
        chk("ras_y", 32'(signed'(bullet_y_a[0])), 200);
        point("p99_200", 99, 200, 1'b1);
        point("p101_208", 101, 208, 1'b1);
        point("p100_204", 100, 204, 1'b1);
        point("p98_200", 98, 200, 1'b0);
        point("p100_209", 100, 209, 1'b0);
        point("p102_200", 102, 200, 1'b0);
        point("p100_199", 100, 199, 1'b0);
        hpos = 12'sd100;
        vpos = 12'sd200;
        #1;
        chk("ras_slot_hit", 32'(slot_hit_a), 32'b0001);

        // Reset while in flight
        do_reset();
        chk("midrst_active", 32'(slot_active_a), 0);
        tick();
        chk("midrst_free", 32'(free_count_a), 4);
        chk("midrst_hit", 32'(active_a), 0);

        // Zero-cooldown instance: fill, drop, kill+fire same fsync, refill
        for (int k = 0; k < 4; k++) begin
            player_x = 12'(10 + k);
            press(1'b1);
            frame();
            chk($sformatf("fill_%0d", k), 32'(slot_active_b), (1 << (k + 1)) - 1);
        end
        tick();
        chk("full_free", 32'(free_count_b), 0);
        press(1'b1);
        frame();
        chk("full_drop", 32'(fire_dropped_b), 1);
        chk("full_active", 32'(slot_active_b), 32'b1111);
        press(1'b1);
        kill_b = 4'b0100;
        frame();
        kill_b = 4'b0000;
        chk("killfire_active", 32'(slot_active_b), 32'b1011);
        chk("killfire_drop", 32'(fire_dropped_b), 1);
        player_x = 12'sd77;
        press(1'b1);
        frame();
        chk("refill_active", 32'(slot_active_b), 32'b1111);
        chk("refill_x2", 32'(signed'(bullet_x_b[2])), 77);
        chk("refill_y2", 32'(signed'(bullet_y_b[2])), 456);
        chk("refill_no_drop", 32'(fire_dropped_b), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
